pq_cmd_sequencer: RTL and testbench

Front-end command sequencer that sits directly upstream of the register-tree priority queue (max-heap, 0 = empty sentinel). It turns independent valid/ready enqueue and dequeue request streams into one-cycle wrt/read/replace pulses on the queue. It holds the queue idle for a settle window after every command so the compare-swap network can restore heap order. It buffers enqueue data in a small FIFO and returns popped values on a valid/ready response port.

---
 rtl/pq_cmd_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_pq_cmd_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_cmd_sequencer.sv
// Command sequencer in front of the register-tree max-heap priority queue.
// Define PQ_SEQ_REPLACE_EN to merge a pop and a pending push into one replace command.
module pq_cmd_sequencer #(
   parameter int DATA_WIDTH    = 16,
   parameter int QUEUE_SIZE    = 3,
   parameter int FIFO_DEPTH    = 4,
   parameter int SETTLE_CYCLES = $clog2(QUEUE_SIZE)
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic                  i_enq_valid,
   output logic                  o_enq_ready,
   input  logic [DATA_WIDTH-1:0] i_enq_data,
   input  logic                  i_deq_valid,
   output logic                  o_deq_ready,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_data,
   output logic                  o_zero_drop,
   output logic                  o_pq_wrt,
   output logic                  o_pq_read,
   output logic [DATA_WIDTH-1:0] o_pq_data,
   input  logic                  i_pq_full,
   input  logic                  i_pq_empty,
   input  logic [DATA_WIDTH-1:0] i_pq_data
);

   localparam int AW  = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
   localparam int SCW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

   localparam logic [AW:0]            FIFO_FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [SCW-1:0]         SETTLE_LOAD   = SCW'(SETTLE_CYCLES);
   localparam logic [DATA_WIDTH-1:0]  DATA_ZERO     = {DATA_WIDTH{1'b0}};

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_SETTLE = 2'd2;

`ifdef PQ_SEQ_REPLACE_EN
   localparam logic REPLACE_EN = 1'b1;
`else
   localparam logic REPLACE_EN = 1'b0;
`endif

   logic [DATA_WIDTH-1:0] fifo_mem_r [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_r;
   logic [AW-1:0]         rd_ptr_r;
   logic [AW:0]           count_r;

   logic [1:0]            state_r;
   logic [SCW-1:0]        settle_cnt_r;
   logic                  pq_wrt_r;
   logic                  pq_read_r;
   logic [DATA_WIDTH-1:0] pq_data_r;
   logic                  rsp_valid_r;
   logic [DATA_WIDTH-1:0] rsp_data_r;
   logic                  zero_drop_r;

   logic                  enq_ready_s;
   logic                  enq_hs_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  fifo_ne_s;
   logic                  deq_ok_s;
   logic                  take_rep_s;
   logic                  take_rd_s;
   logic                  take_wr_s;
   logic [DATA_WIDTH-1:0] head_s;

   // Enqueue handshake qualification and FIFO status.
   always_comb begin
      enq_ready_s = (count_r != FIFO_FULL_CNT);
      enq_hs_s    = i_enq_valid && enq_ready_s;
      push_s      = enq_hs_s && (i_enq_data != DATA_ZERO);
      fifo_ne_s   = (count_r != {(AW+1){1'b0}});
      head_s      = fifo_mem_r[rd_ptr_r];
      deq_ok_s    = i_deq_valid && !i_pq_empty && !rsp_valid_r;
   end

   // IDLE command arbitration: replace, then read, then write.
   always_comb begin
      take_rep_s = 1'b0;
      take_rd_s  = 1'b0;
      take_wr_s  = 1'b0;
      if (state_r == ST_IDLE) begin
         if (REPLACE_EN && deq_ok_s && fifo_ne_s) begin
            take_rep_s = 1'b1;
         end else if (deq_ok_s) begin
            take_rd_s = 1'b1;
         end else if (fifo_ne_s && !i_pq_full) begin
            take_wr_s = 1'b1;
         end else begin
            take_wr_s = 1'b0;
         end
      end else begin
         take_rep_s = 1'b0;
      end
      pop_s = take_rep_s || take_wr_s;
   end

   // Enqueue buffer storage; contents need no reset since count gates every read.
   always_ff @(posedge i_CLK) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= i_enq_data;
      end
   end

   // Enqueue buffer pointers and occupancy.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Zero-valued enqueues are accepted but flagged instead of stored.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         zero_drop_r <= 1'b0;
      end else begin
         zero_drop_r <= enq_hs_s && (i_enq_data == DATA_ZERO);
      end
   end

   // Command FSM: one ISSUE cycle, then a settle window so the heap can reorder.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_r      <= ST_IDLE;
         settle_cnt_r <= {SCW{1'b0}};
         pq_wrt_r     <= 1'b0;
         pq_read_r    <= 1'b0;
         pq_data_r    <= DATA_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (take_rep_s || take_rd_s || take_wr_s) begin
                  state_r   <= ST_ISSUE;
                  pq_wrt_r  <= take_rep_s || take_wr_s;
                  pq_read_r <= take_rep_s || take_rd_s;
                  pq_data_r <= (take_rep_s || take_wr_s) ? head_s : DATA_ZERO;
               end else begin
                  pq_wrt_r  <= 1'b0;
                  pq_read_r <= 1'b0;
                  pq_data_r <= DATA_ZERO;
               end
            end
            ST_ISSUE: begin
               state_r      <= ST_SETTLE;
               settle_cnt_r <= SETTLE_LOAD;
               pq_wrt_r     <= 1'b0;
               pq_read_r    <= 1'b0;
               pq_data_r    <= DATA_ZERO;
            end
            ST_SETTLE: begin
               if (settle_cnt_r <= SCW'(1)) begin
                  state_r      <= ST_IDLE;
                  settle_cnt_r <= {SCW{1'b0}};
               end else begin
                  settle_cnt_r <= settle_cnt_r - SCW'(1);
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               settle_cnt_r <= {SCW{1'b0}};
               pq_wrt_r     <= 1'b0;
               pq_read_r    <= 1'b0;
               pq_data_r    <= DATA_ZERO;
            end
         endcase
      end
   end

   // Root is captured at the end of a read/replace ISSUE and held until consumed.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= DATA_ZERO;
      end else if ((state_r == ST_ISSUE) && pq_read_r) begin
         rsp_valid_r <= 1'b1;
         rsp_data_r  <= i_pq_data;
      end else if (rsp_valid_r && i_rsp_ready) begin
         rsp_valid_r <= 1'b0;
      end else begin
         rsp_valid_r <= rsp_valid_r;
      end
   end

   assign o_enq_ready = enq_ready_s;
   assign o_deq_ready = (take_rep_s || take_rd_s) && !i_RST;
   assign o_rsp_valid = rsp_valid_r;
   assign o_rsp_data  = rsp_data_r;
   assign o_zero_drop = zero_drop_r;
   assign o_pq_wrt    = pq_wrt_r;
   assign o_pq_read   = pq_read_r;
   assign o_pq_data   = pq_data_r;

endmodule

// File: tb/tb_pq_cmd_sequencer.sv
// Directed self-checking bench for pq_cmd_sequencer (SETTLE_CYCLES=2, FIFO_DEPTH=4).
module tb_pq_cmd_sequencer;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enq_valid = 1'b0;
   logic          enq_ready;
   logic [DW-1:0] enq_data = 16'd0;
   logic          deq_valid = 1'b0;
   logic          deq_ready;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_data;
   logic          zero_drop;
   logic          pq_wrt;
   logic          pq_read;
   logic [DW-1:0] pq_data;
   logic          pq_full = 1'b0;
   logic          pq_empty = 1'b1;
   logic [DW-1:0] pq_root = 16'd0;

   int errors = 0;
   int checks = 0;

   pq_cmd_sequencer #(
      .DATA_WIDTH(DW), .QUEUE_SIZE(3), .FIFO_DEPTH(4), .SETTLE_CYCLES(2)
   ) dut (
      .i_CLK(clk), .i_RST(rst),
      .i_enq_valid(enq_valid), .o_enq_ready(enq_ready), .i_enq_data(enq_data),
      .i_deq_valid(deq_valid), .o_deq_ready(deq_ready),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
      .o_zero_drop(zero_drop),
      .o_pq_wrt(pq_wrt), .o_pq_read(pq_read), .o_pq_data(pq_data),
      .i_pq_full(pq_full), .i_pq_empty(pq_empty), .i_pq_data(pq_root)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      int pulses;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      checks++;
      if ({pq_wrt, pq_read, rsp_valid, zero_drop, enq_ready, deq_ready} !== 6'b000010) begin
         errors++;
         $display("FAIL reset_flags: got %b expected %b",
                  {pq_wrt, pq_read, rsp_valid, zero_drop, enq_ready, deq_ready}, 6'b000010);
      end
      checks++;
      if (pq_data !== 16'd0 || rsp_data !== 16'd0) begin
         errors++;
         $display("FAIL reset_data: got pq_data=%0d rsp_data=%0d expected 0 0", pq_data, rsp_data);
      end
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (pq_wrt !== 1'b0 || pq_read !== 1'b0) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL reset_idle_pulses: got %0d expected 0", pulses);
      end
   endtask

   task automatic test_back_to_back;
      int            pt [$];
      logic [DW-1:0] pd [$];
      logic [DW-1:0] vals [3];
      int            bad;
      vals[0] = 16'd5; vals[1] = 16'd9; vals[2] = 16'd3;
      bad = 0;
      for (int c = 0; c < 30; c++) begin
         if (pq_wrt === 1'b1) begin
            pt.push_back(c);
            pd.push_back(pq_data);
            if (pq_read !== 1'b0) bad++;
         end else if (pq_data !== 16'd0 || pq_read !== 1'b0) begin
            bad++;
         end
         if (enq_ready !== 1'b1) bad++;
         enq_valid = (c < 3);
         enq_data  = (c < 3) ? vals[c] : 16'd0;
         tick();
      end
      enq_valid = 1'b0;
      checks++;
      if (pt.size() != 3) begin
         errors++;
         $display("FAIL b2b_pulse_count: got %0d expected 3", pt.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (pd[i] !== vals[i]) begin
               errors++;
               $display("FAIL b2b_data%0d: got %0d expected %0d", i, pd[i], vals[i]);
            end
         end
         checks++;
         if (pt[0] != 2 || pt[1] - pt[0] != 4 || pt[2] - pt[1] != 4) begin
            errors++;
            $display("FAIL b2b_spacing: got cycles %0d %0d %0d expected 2 6 10", pt[0], pt[1], pt[2]);
         end
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL b2b_side_outputs: got %0d violations expected 0", bad);
      end
   endtask

   task automatic test_read;
      pq_empty  = 1'b0;
      pq_root   = 16'd9;
      deq_valid = 1'b1;
      #1;
      checks++;
      if (deq_ready !== 1'b1) begin
         errors++;
         $display("FAIL read_deq_ready: got %b expected 1", deq_ready);
      end
      tick();
      deq_valid = 1'b0;
      checks++;
      if ({pq_read, pq_wrt, rsp_valid} !== 3'b100 || pq_data !== 16'd0) begin
         errors++;
         $display("FAIL read_issue: got read/wrt/rsp=%b data=%0d expected 100 data=0",
                  {pq_read, pq_wrt, rsp_valid}, pq_data);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'd9 || pq_read !== 1'b0) begin
         errors++;
         $display("FAIL read_rsp: got valid=%b data=%0d read=%b expected 1 9 0", rsp_valid, rsp_data, pq_read);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL read_rsp_clear: got %b expected 0", rsp_valid);
      end
      pq_empty = 1'b1;
      repeat (5) tick();
   endtask

   task automatic test_zero_drop;
      int wr_cnt;
      int zd_cnt;
      enq_valid = 1'b1;
      enq_data  = 16'd0;
      tick();
      enq_valid = 1'b0;
      checks++;
      if (zero_drop !== 1'b1) begin
         errors++;
         $display("FAIL zero_drop_pulse: got %b expected 1", zero_drop);
      end
      wr_cnt = 0;
      zd_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (pq_wrt === 1'b1) wr_cnt++;
         if (zero_drop === 1'b1) zd_cnt++;
      end
      checks++;
      if (wr_cnt !== 0 || zd_cnt !== 0) begin
         errors++;
         $display("FAIL zero_drop_after: got wrt=%0d drop=%0d expected 0 0", wr_cnt, zd_cnt);
      end
   endtask

   task automatic test_full_backpressure;
      logic [DW-1:0] got [$];
      int            early;
      pq_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         enq_valid = 1'b1;
         enq_data  = 16'(11 + i);
         tick();
         checks++;
         if (enq_ready !== ((i < 3) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL full_enq_ready%0d: got %b expected %b", i, enq_ready, (i < 3) ? 1'b1 : 1'b0);
         end
      end
      enq_valid = 1'b0;
      early = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (pq_wrt === 1'b1) early++;
      end
      checks++;
      if (early !== 0) begin
         errors++;
         $display("FAIL full_no_write: got %0d pulses expected 0", early);
      end
      pq_full = 1'b0;
      for (int c = 0; c < 24; c++) begin
         tick();
         if (pq_wrt === 1'b1) got.push_back(pq_data);
      end
      checks++;
      if (got.size() != 4) begin
         errors++;
         $display("FAIL full_drain_count: got %0d expected 4", got.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== 16'(11 + i)) begin
               errors++;
               $display("FAIL full_drain_data%0d: got %0d expected %0d", i, got[i], 11 + i);
            end
         end
      end
   endtask

   task automatic test_replace;
      int wr_at;
      logic [DW-1:0] wr_val;
      pq_full   = 1'b1;
      enq_valid = 1'b1;
      enq_data  = 16'd7;
      tick();
      enq_valid = 1'b0;
      pq_empty  = 1'b0;
      pq_root   = 16'd9;
      deq_valid = 1'b1;
      #1;
      checks++;
      if (deq_ready !== 1'b1) begin
         errors++;
         $display("FAIL repl_deq_ready: got %b expected 1", deq_ready);
      end
      tick();
      deq_valid = 1'b0;
      pq_full   = 1'b0;
`ifdef PQ_SEQ_REPLACE_EN
      checks++;
      if ({pq_wrt, pq_read} !== 2'b11 || pq_data !== 16'd7) begin
         errors++;
         $display("FAIL repl_issue: got wrt/read=%b data=%0d expected 11 7", {pq_wrt, pq_read}, pq_data);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'd9) begin
         errors++;
         $display("FAIL repl_rsp: got valid=%b data=%0d expected 1 9", rsp_valid, rsp_data);
      end
      wr_at = -1;
      for (int c = 0; c < 10; c++) begin
         if (pq_wrt === 1'b1 && wr_at < 0) wr_at = c;
         tick();
      end
      checks++;
      if (wr_at !== -1) begin
         errors++;
         $display("FAIL repl_extra_write: got write at %0d expected none", wr_at);
      end
`else
      checks++;
      if ({pq_wrt, pq_read} !== 2'b01) begin
         errors++;
         $display("FAIL serial_read_issue: got wrt/read=%b expected 01", {pq_wrt, pq_read});
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'd9) begin
         errors++;
         $display("FAIL serial_rsp: got valid=%b data=%0d expected 1 9", rsp_valid, rsp_data);
      end
      wr_at  = -1;
      wr_val = 16'd0;
      for (int c = 0; c < 10; c++) begin
         if (pq_wrt === 1'b1 && wr_at < 0) begin
            wr_at  = c;
            wr_val = pq_data;
         end
         tick();
      end
      checks++;
      if (wr_at !== 3 || wr_val !== 16'd7) begin
         errors++;
         $display("FAIL serial_write: got cycle=%0d data=%0d expected 3 7", wr_at, wr_val);
      end
`endif
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      pq_empty  = 1'b1;
      repeat (5) tick();
   endtask

   task automatic test_rsp_hold;
      int bad;
      pq_empty  = 1'b0;
      pq_root   = 16'd20;
      deq_valid = 1'b1;
      #1;
      checks++;
      if (deq_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_first_ready: got %b expected 1", deq_ready);
      end
      tick();
      tick();
      pq_root = 16'd25;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'd20) begin
         errors++;
         $display("FAIL hold_first_rsp: got valid=%b data=%0d expected 1 20", rsp_valid, rsp_data);
      end
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         if (deq_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 16'd20 || pq_read !== 1'b0) bad++;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL hold_stall: got %0d violations expected 0", bad);
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (deq_ready !== 1'b0) begin
         errors++;
         $display("FAIL hold_ready_during_hs: got %b expected 0", deq_ready);
      end
      tick();
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || deq_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_release: got valid=%b deq_ready=%b expected 0 1", rsp_valid, deq_ready);
      end
      tick();
      deq_valid = 1'b0;
      checks++;
      if (pq_read !== 1'b1) begin
         errors++;
         $display("FAIL hold_second_read: got %b expected 1", pq_read);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'd25) begin
         errors++;
         $display("FAIL hold_second_rsp: got valid=%b data=%0d expected 1 25", rsp_valid, rsp_data);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      pq_empty  = 1'b1;
      repeat (5) tick();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_read();
      test_zero_drop();
      test_full_backpressure();
      test_replace();
      test_rsp_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
